// File: rtl/bus_dest_regs_if.sv
// Common-bus destination bundle: bus/ALU data and per-register controls in,
// register bank contents and control-error status out.
interface bus_dest_regs_if #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 12
);
    logic [WIDTH-1:0]  BUS_IN;
    logic [WIDTH-1:0]  ALU_IN;
    logic [5:0]        LD;
    logic [5:0]        INR;
    logic [5:0]        CLR;
    logic [AWIDTH-1:0] AR;
    logic [AWIDTH-1:0] PC;
    logic [WIDTH-1:0]  DR;
    logic [WIDTH-1:0]  AC;
    logic [WIDTH-1:0]  IR;
    logic [WIDTH-1:0]  TR;
    logic              CTRL_ERR;
    logic [2:0]        ERR_IDX;

    modport master (
        output BUS_IN, ALU_IN, LD, INR, CLR,
        input  AR, PC, DR, AC, IR, TR, CTRL_ERR, ERR_IDX
    );

    modport slave (
        input  BUS_IN, ALU_IN, LD, INR, CLR,
        output AR, PC, DR, AC, IR, TR, CTRL_ERR, ERR_IDX
    );
endinterface

// File: rtl/bus_dest_regs.sv
// Register bank on the destination side of the common bus (AR PC DR AC IR TR)
// with CLR > LD > INR per register and a sticky multi-control error flag.
module bus_dest_regs #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 12
) (
    input  logic            CLK,
    input  logic            RST,
    bus_dest_regs_if.slave  bus
);
    localparam int I_AR = 0;
    localparam int I_PC = 1;
    localparam int I_DR = 2;
    localparam int I_AC = 3;
    localparam int I_IR = 4;
    localparam int I_TR = 5;

    logic [AWIDTH-1:0] ar_q, ar_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]  dr_q, dr_d;
    logic [WIDTH-1:0]  ac_q, ac_d;
    logic [WIDTH-1:0]  ir_q, ir_d;
    logic [WIDTH-1:0]  tr_q, tr_d;
    logic              err_q, err_d;
    logic [2:0]        idx_q, idx_d;

    logic [5:0]        conflict;
    logic [2:0]        low_idx;
    logic [AWIDTH-1:0] bus_addr;

    assign bus_addr = bus.BUS_IN[AWIDTH-1:0];

    function automatic logic [AWIDTH-1:0] next_a(
        input logic [AWIDTH-1:0] cur,
        input logic [AWIDTH-1:0] src,
        input logic              clr,
        input logic              ld,
        input logic              inr
    );
        logic [AWIDTH-1:0] r;
        r = cur;
        if (clr)      r = '0;
        else if (ld)  r = src;
        else if (inr) r = cur + 1'b1;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] next_w(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] src,
        input logic             clr,
        input logic             ld,
        input logic             inr
    );
        logic [WIDTH-1:0] r;
        r = cur;
        if (clr)      r = '0;
        else if (ld)  r = src;
        else if (inr) r = cur + 1'b1;
        return r;
    endfunction

    always_comb begin
        ar_d = next_a(ar_q, bus_addr, bus.CLR[I_AR], bus.LD[I_AR], bus.INR[I_AR]);
        pc_d = next_a(pc_q, bus_addr, bus.CLR[I_PC], bus.LD[I_PC], bus.INR[I_PC]);
        dr_d = next_w(dr_q, bus.BUS_IN, bus.CLR[I_DR], bus.LD[I_DR], bus.INR[I_DR]);
        ac_d = next_w(ac_q, bus.ALU_IN, bus.CLR[I_AC], bus.LD[I_AC], bus.INR[I_AC]);
        ir_d = next_w(ir_q, bus.BUS_IN, bus.CLR[I_IR], bus.LD[I_IR], bus.INR[I_IR]);
        tr_d = next_w(tr_q, bus.BUS_IN, bus.CLR[I_TR], bus.LD[I_TR], bus.INR[I_TR]);
    end

    assign conflict = (bus.LD & bus.INR) | (bus.LD & bus.CLR) | (bus.INR & bus.CLR);

    // Scan downwards so the lowest conflicting index wins.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (conflict[i]) low_idx = 3'(i);
        end
    end

    always_comb begin
        err_d = err_q;
        idx_d = idx_q;
        if (!err_q && (|conflict)) begin
            err_d = 1'b1;
            idx_d = low_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ar_q  <= '0;
            pc_q  <= '0;
            dr_q  <= '0;
            ac_q  <= '0;
            ir_q  <= '0;
            tr_q  <= '0;
            err_q <= 1'b0;
            idx_q <= 3'd0;
        end else begin
            ar_q  <= ar_d;
            pc_q  <= pc_d;
            dr_q  <= dr_d;
            ac_q  <= ac_d;
            ir_q  <= ir_d;
            tr_q  <= tr_d;
            err_q <= err_d;
            idx_q <= idx_d;
        end
    end

    assign bus.AR       = ar_q;
    assign bus.PC       = pc_q;
    assign bus.DR       = dr_q;
    assign bus.AC       = ac_q;
    assign bus.IR       = ir_q;
    assign bus.TR       = tr_q;
    assign bus.CTRL_ERR = err_q;
    assign bus.ERR_IDX  = idx_q;
endmodule

// File: tb/tb_bus_dest_regs.sv
// Directed vector table, RMW sequence and random run against a reference model.
module tb_bus_dest_regs;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    bus_dest_regs_if #(.WIDTH(16), .AWIDTH(12)) bif ();

    bus_dest_regs #(.WIDTH(16), .AWIDTH(12)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bif.slave)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  ld, inr, clr;
        logic [15:0] b, a;
        logic [11:0] ar, pc;
        logic [15:0] dr, ac, ir, tr;
        logic        err;
        logic [2:0]  idx;
    } vec_t;

    vec_t vt[16];
    int checks = 0;
    int passed = 0;

    logic [15:0] m[6];
    logic        merr;
    logic [2:0]  midx;

    function automatic logic [91:0] actual();
        return {bif.AR, bif.PC, bif.DR, bif.AC, bif.IR, bif.TR,
                bif.CTRL_ERR, bif.ERR_IDX};
    endfunction

    function automatic logic [91:0] model_out();
        return {m[0][11:0], m[1][11:0], m[2], m[3], m[4], m[5], merr, midx};
    endfunction

    task automatic check(input string name, input logic [91:0] exp);
        logic [91:0] got;
        got = actual();
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    task automatic model_step(input logic rst, input logic [5:0] ld, inr, clr,
                              input logic [15:0] b, a);
        logic [15:0] msk;
        int n;
        bit found;
        if (rst) begin
            for (int i = 0; i < 6; i++) m[i] = 16'h0;
            merr = 1'b0;
            midx = 3'd0;
        end else begin
            found = 0;
            for (int i = 0; i < 6; i++) begin
                n = int'(ld[i]) + int'(inr[i]) + int'(clr[i]);
                if (n >= 2 && !merr && !found) begin
                    found = 1;
                    midx = 3'(i);
                end
                msk = (i < 2) ? 16'h0FFF : 16'hFFFF;
                case ({clr[i], ld[i], inr[i]}) inside
                    3'b1??:  m[i] = 16'h0;
                    3'b01?:  m[i] = ((i == 3) ? a : b) & msk;
                    3'b001:  m[i] = (m[i] + 16'h1) & msk;
                    default: m[i] = m[i];
                endcase
            end
            if (found) merr = 1'b1;
        end
    endtask

    task automatic step(input logic rst, input logic [5:0] ld, inr, clr,
                        input logic [15:0] b, a);
        RST = rst;
        bif.LD = ld;
        bif.INR = inr;
        bif.CLR = clr;
        bif.BUS_IN = b;
        bif.ALU_IN = a;
        @(posedge CLK);
        model_step(rst, ld, inr, clr, b, a);
        #1;
    endtask

    function automatic vec_t mk(logic rst, logic [5:0] ld, inr, clr,
                                logic [15:0] b, a, logic [11:0] ar, pc,
                                logic [15:0] dr, ac, ir, tr,
                                logic err, logic [2:0] idx);
        vec_t v;
        v.rst = rst; v.ld = ld; v.inr = inr; v.clr = clr; v.b = b; v.a = a;
        v.ar = ar; v.pc = pc; v.dr = dr; v.ac = ac; v.ir = ir; v.tr = tr;
        v.err = err; v.idx = idx;
        return v;
    endfunction

    initial begin
        vt[0]  = mk(1, 6'h00, 6'h00, 6'h00, 16'h0000, 16'h0000,
                    12'h000, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        vt[1]  = mk(0, 6'h3F, 6'h00, 6'h00, 16'hBEEF, 16'h1111,
                    12'hEEF, 12'hEEF, 16'hBEEF, 16'h1111, 16'hBEEF, 16'hBEEF, 0, 0);
        vt[2]  = mk(1, 6'h3F, 6'h00, 6'h00, 16'hBEEF, 16'h1111,
                    12'h000, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        vt[3]  = mk(0, 6'h3F, 6'h00, 6'h00, 16'hA5C3, 16'h1234,
                    12'h5C3, 12'h5C3, 16'hA5C3, 16'h1234, 16'hA5C3, 16'hA5C3, 0, 0);
        vt[4]  = mk(0, 6'h02, 6'h00, 6'h00, 16'h0FFE, 16'h0000,
                    12'h5C3, 12'hFFE, 16'hA5C3, 16'h1234, 16'hA5C3, 16'hA5C3, 0, 0);
        vt[5]  = mk(0, 6'h20, 6'h00, 6'h00, 16'hFFFF, 16'h0000,
                    12'h5C3, 12'hFFE, 16'hA5C3, 16'h1234, 16'hA5C3, 16'hFFFF, 0, 0);
        vt[6]  = mk(0, 6'h00, 6'h22, 6'h00, 16'h0000, 16'h0000,
                    12'h5C3, 12'hFFF, 16'hA5C3, 16'h1234, 16'hA5C3, 16'h0000, 0, 0);
        vt[7]  = mk(0, 6'h00, 6'h22, 6'h00, 16'h0000, 16'h0000,
                    12'h5C3, 12'h000, 16'hA5C3, 16'h1234, 16'hA5C3, 16'h0001, 0, 0);
        vt[8]  = mk(0, 6'h04, 6'h00, 6'h00, 16'h0042, 16'h0000,
                    12'h5C3, 12'h000, 16'h0042, 16'h1234, 16'hA5C3, 16'h0001, 0, 0);
        vt[9]  = mk(0, 6'h14, 6'h14, 6'h04, 16'h7777, 16'h0000,
                    12'h5C3, 12'h000, 16'h0000, 16'h1234, 16'h7777, 16'h0001, 1, 2);
        vt[10] = mk(0, 6'h01, 6'h00, 6'h01, 16'h0123, 16'h0000,
                    12'h000, 12'h000, 16'h0000, 16'h1234, 16'h7777, 16'h0001, 1, 2);
        vt[11] = mk(0, 6'h00, 6'h00, 6'h00, 16'hFFFF, 16'hFFFF,
                    12'h000, 12'h000, 16'h0000, 16'h1234, 16'h7777, 16'h0001, 1, 2);
        vt[12] = mk(1, 6'h00, 6'h00, 6'h00, 16'h0000, 16'h0000,
                    12'h000, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        vt[13] = mk(0, 6'h00, 6'h08, 6'h00, 16'h0000, 16'h0000,
                    12'h000, 12'h000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 0, 0);
        vt[14] = mk(0, 6'h28, 6'h28, 6'h00, 16'h9999, 16'h5555,
                    12'h000, 12'h000, 16'h0000, 16'h5555, 16'h0000, 16'h9999, 1, 3);
        vt[15] = mk(1, 6'h3F, 6'h3F, 6'h3F, 16'hFFFF, 16'hFFFF,
                    12'h000, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);

        for (int k = 0; k < 16; k++) begin
            step(vt[k].rst, vt[k].ld, vt[k].inr, vt[k].clr, vt[k].b, vt[k].a);
            check($sformatf("vec%0d", k),
                  {vt[k].ar, vt[k].pc, vt[k].dr, vt[k].ac, vt[k].ir, vt[k].tr,
                   vt[k].err, vt[k].idx});
        end

        step(0, 6'h08, 6'h00, 6'h00, 16'h0000, 16'h00FF);
        check("rmw_init", {12'h000, 12'h000, 16'h0000, 16'h00FF, 16'h0000,
                           16'h0000, 1'b0, 3'd0});
        for (int k = 0; k < 3; k++) begin
            step(0, 6'h08, 6'h00, 6'h00, 16'h0000, bif.AC + 16'h1);
            check($sformatf("rmw%0d", k),
                  {12'h000, 12'h000, 16'h0000, 16'h0100 + 16'(k), 16'h0000,
                   16'h0000, 1'b0, 3'd0});
        end
        for (int k = 0; k < 2; k++) begin
            step(0, 6'h00, 6'h00, 6'h00, 16'hDEAD, 16'hBEEF);
            check($sformatf("hold%0d", k),
                  {12'h000, 12'h000, 16'h0000, 16'h0102, 16'h0000,
                   16'h0000, 1'b0, 3'd0});
        end

        step(1, 6'h00, 6'h00, 6'h00, 16'h0000, 16'h0000);
        for (int k = 0; k < 10000; k++) begin
            step(($urandom_range(0, 255) == 0),
                 6'($urandom), 6'($urandom) & 6'($urandom), 6'($urandom) & 6'($urandom),
                 16'($urandom), 16'($urandom));
            check($sformatf("rand%0d", k), model_out());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
